// File: rtl/fpu_pkg.sv
// Shared FPU definitions: packed float layout, status encoding and normalizer states.
package fpu_pkg;

  localparam int EXP_W   = 6;
  localparam int FRAC_W  = 25;
  localparam int EXP_MAX = 62;
  localparam logic [EXP_W-1:0] EXP_OVF = 6'd63;

  localparam int ST_EXACT     = 0;
  localparam int ST_INEXACT   = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_UNDERFLOW = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_PACK  = 2'd3
  } norm_state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fpu_word_t;

  function automatic logic [3:0] status_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/fpu_round.sv
// Round-to-nearest-even on a normalized mantissa {carry, hidden, frac[24:0], guard}.
module fpu_round
  import fpu_pkg::*;
(
  input  logic [27:0] m_i,
  input  logic        st_i,
  output logic [27:0] m_o,
  output logic        carry_o,
  output logic        inexact_o
);

  logic        inc;
  logic [26:0] sum;

  assign inc       = m_i[0] & (st_i | m_i[1]);
  assign sum       = m_i[27:1] + {26'd0, inc};
  // m[27] is always clear on entry, so sum[26] set means the round carried out
  assign carry_o   = sum[26];
  assign inexact_o = m_i[0] | st_i;
  assign m_o       = carry_o ? {1'b0, sum} : {sum, m_i[0]};

endmodule

// File: rtl/fpu_normalizer.sv
// Post-adder normalize (one bit per cycle), round-to-nearest-even and pack stage.
module fpu_normalizer
  import fpu_pkg::*;
(
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic        start,
  input  logic        sign_in,
  input  logic [7:0]  exp_in,
  input  logic [27:0] mant_in,
  input  logic        sticky_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] data_out,
  output logic [3:0]  status_out
);

  norm_state_e state_q;
  logic [27:0] m_q;
  logic [7:0]  e_q;
  logic        s_q, st_q;
  logic        zero_q, uf_q, inx_q;
  logic        done_q;
  logic [31:0] data_q;
  logic [3:0]  status_q;

  logic [27:0] rnd_m;
  logic        rnd_carry, rnd_inexact;
  fpu_word_t   word;

  fpu_round u_round (
    .m_i      (m_q),
    .st_i     (st_q),
    .m_o      (rnd_m),
    .carry_o  (rnd_carry),
    .inexact_o(rnd_inexact)
  );

  always_comb begin
    word.sign = s_q;
    word.exp  = e_q[EXP_W-1:0];
    word.frac = m_q[25:1];
  end

  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      data_q   <= 32'd0;
      status_q <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            m_q     <= mant_in;
            e_q     <= exp_in;
            s_q     <= sign_in;
            st_q    <= sticky_in;
            zero_q  <= 1'b0;
            uf_q    <= 1'b0;
            inx_q   <= 1'b0;
            state_q <= S_NORM;
          end
        end
        S_NORM: begin
          if (m_q == 28'd0) begin
            zero_q  <= 1'b1;
            state_q <= S_PACK;
          end else if (m_q[27]) begin
            m_q     <= {1'b0, m_q[27:1]};
            e_q     <= e_q + 8'd1;
            st_q    <= st_q | m_q[0];
            state_q <= S_ROUND;
          end else if (m_q[26]) begin
            state_q <= S_ROUND;
          end else if (e_q <= 8'd1) begin
            uf_q    <= 1'b1;
            state_q <= S_PACK;
          end else begin
            m_q <= {m_q[26:0], 1'b0};
            e_q <= e_q - 8'd1;
          end
        end
        S_ROUND: begin
          m_q     <= rnd_m;
          inx_q   <= rnd_inexact;
          if (rnd_carry) e_q <= e_q + 8'd1;
          state_q <= S_PACK;
        end
        S_PACK: begin
          if (zero_q) begin
            data_q   <= {s_q, 31'd0};
            status_q <= status_onehot(2'(ST_EXACT));
          end else if (uf_q) begin
            data_q   <= {s_q, 31'd0};
            status_q <= status_onehot(2'(ST_UNDERFLOW));
          end else if (e_q > 8'(EXP_MAX)) begin
            data_q   <= {s_q, EXP_OVF, {FRAC_W{1'b0}}};
            status_q <= status_onehot(2'(ST_OVERFLOW));
          end else begin
            data_q   <= word;
            status_q <= inx_q ? status_onehot(2'(ST_INEXACT))
                              : status_onehot(2'(ST_EXACT));
          end
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign data_out   = data_q;
  assign status_out = status_q;

endmodule
